// File: rtl/egg_timer_pkg.sv
// Shared types and defaults for the egg timer controller.
// No logic; state encoding is visible on the debug port.
package egg_timer_pkg;

    localparam int DIGIT_W        = 4;
    localparam int MAX_MIN_DEF    = 99;
    localparam int ALARM_SECS_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/mmss_counter.sv
// mm:ss BCD time register with clear, minute/second increment and one-second decrement.
// Latency: digits update one cycle after a command; is_zero looks ahead at the next value.
// Backpressure: none, commands are applied in the cycle they are asserted.
module mmss_counter
    import egg_timer_pkg::*;
#(
    parameter int MAX_MIN = MAX_MIN_DEF
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               load_zero,
    input  logic               inc_min,
    input  logic               inc_sec,
    input  logic               dec,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               is_zero
);

    localparam logic [DIGIT_W-1:0] MAX_T = DIGIT_W'(MAX_MIN / 10);
    localparam logic [DIGIT_W-1:0] MAX_O = DIGIT_W'(MAX_MIN % 10);

    logic [DIGIT_W-1:0] mt_q, mo_q, st_q, so_q;
    logic [DIGIT_W-1:0] mt_d, mo_d, st_d, so_d;

    always_comb begin
        mt_d = mt_q;
        mo_d = mo_q;
        st_d = st_q;
        so_d = so_q;
        if (load_zero) begin
            mt_d = '0;
            mo_d = '0;
            st_d = '0;
            so_d = '0;
        end else begin
            if (inc_min) begin
                if (mt_q == MAX_T && mo_q == MAX_O) begin
                    mt_d = '0;
                    mo_d = '0;
                end else if (mo_q == 4'd9) begin
                    mo_d = '0;
                    mt_d = mt_q + 4'd1;
                end else begin
                    mo_d = mo_q + 4'd1;
                end
            end
            // seconds wrap on their own, never carrying into minutes
            if (inc_sec) begin
                if (st_q == 4'd5 && so_q == 4'd9) begin
                    st_d = '0;
                    so_d = '0;
                end else if (so_q == 4'd9) begin
                    so_d = '0;
                    st_d = st_q + 4'd1;
                end else begin
                    so_d = so_q + 4'd1;
                end
            end
            if (dec) begin
                if (st_q == 4'd0 && so_q == 4'd0) begin
                    st_d = 4'd5;
                    so_d = 4'd9;
                    if (mo_q == 4'd0) begin
                        mo_d = 4'd9;
                        mt_d = mt_q - 4'd1;
                    end else begin
                        mo_d = mo_q - 4'd1;
                    end
                end else if (so_q == 4'd0) begin
                    so_d = 4'd9;
                    st_d = st_q - 4'd1;
                end else begin
                    so_d = so_q - 4'd1;
                end
            end
        end
        is_zero = (mt_d == '0) && (mo_d == '0) && (st_d == '0) && (so_d == '0);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            mt_q <= '0;
            mo_q <= '0;
            st_q <= '0;
            so_q <= '0;
        end else begin
            mt_q <= mt_d;
            mo_q <= mo_d;
            st_q <= st_d;
            so_q <= so_d;
        end
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;

endmodule

// File: rtl/egg_timer_ctrl.sv
// Kitchen egg timer: button-driven mm:ss setting, 1 Hz countdown, timed alarm.
// Latency: buttons reach outputs in 1 cycle; tick_clk edges in 3 cycles.
// Backpressure: none; buttons are single-cycle pulses, lower-priority ones are dropped.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int ALARM_SECS = ALARM_SECS_DEF,
    parameter int MAX_MIN    = MAX_MIN_DEF
) (
    input  logic               clk_in,
    input  logic               reset_n,
    input  logic               tick_clk,
    input  logic               btn_start,
    input  logic               btn_stop,
    input  logic               btn_min,
    input  logic               btn_sec,
    input  logic               btn_clear,
    output logic               div_enable,
    output logic               div_reset,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               alarm,
    output logic [2:0]         state_o
);

    localparam int ACW = (ALARM_SECS < 1) ? 1 : $clog2(ALARM_SECS + 1);

    state_t           state_q, state_d;
    logic [ACW-1:0]   alarm_cnt_q, alarm_cnt_d;
    logic [1:0]       sync_q;
    logic             sync_prev_q;
    logic [2:0]       prime_q;
    logic             tick_pulse;
    logic             load_zero, inc_min, inc_sec, dec, cnt_zero;
    logic             running_q, running_d;
    logic             alarm_q, alarm_d;
    logic             div_enable_q, div_enable_d;
    logic             div_reset_q, div_reset_d;

    // prime_q masks edges until the edge detector holds real history,
    // so a high tick_clk at reset release is not mistaken for an edge
    assign tick_pulse = sync_q[1] & ~sync_prev_q & prime_q[2];

    mmss_counter #(.MAX_MIN(MAX_MIN)) u_mmss (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .load_zero (load_zero),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .dec       (dec),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .is_zero   (cnt_zero)
    );

    always_comb begin
        state_d     = state_q;
        alarm_cnt_d = alarm_cnt_q;
        load_zero   = 1'b0;
        inc_min     = 1'b0;
        inc_sec     = 1'b0;
        dec         = 1'b0;
        div_reset_d = 1'b0;
        if (btn_clear) begin
            load_zero   = 1'b1;
            state_d     = ST_IDLE;
            alarm_cnt_d = '0;
        end else if (btn_stop) begin
            // a stop also swallows any tick arriving in the same cycle
            if (state_q == ST_RUN) begin
                state_d = ST_PAUSE;
            end else if (state_q == ST_DONE) begin
                state_d     = ST_IDLE;
                alarm_cnt_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_SET: begin
                    if (btn_start) begin
                        if (state_q == ST_SET) begin
                            state_d     = ST_RUN;
                            div_reset_d = 1'b1;
                        end
                    end else if (btn_min || btn_sec) begin
                        inc_min = btn_min;
                        inc_sec = btn_sec;
                        state_d = cnt_zero ? ST_IDLE : ST_SET;
                    end
                end
                ST_PAUSE: begin
                    if (btn_start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (tick_pulse) begin
                        dec = 1'b1;
                        if (cnt_zero) begin
                            state_d     = (ALARM_SECS > 0) ? ST_DONE : ST_IDLE;
                            alarm_cnt_d = ACW'(ALARM_SECS);
                        end
                    end
                end
                ST_DONE: begin
                    if (tick_pulse) begin
                        if (alarm_cnt_q <= ACW'(1)) begin
                            state_d     = ST_IDLE;
                            alarm_cnt_d = '0;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q - ACW'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        running_d    = (state_d == ST_RUN);
        alarm_d      = (state_d == ST_DONE);
        div_enable_d = (state_d == ST_RUN) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            alarm_cnt_q  <= '0;
            sync_q       <= '0;
            sync_prev_q  <= 1'b0;
            prime_q      <= '0;
            running_q    <= 1'b0;
            alarm_q      <= 1'b0;
            div_enable_q <= 1'b0;
            div_reset_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            alarm_cnt_q  <= alarm_cnt_d;
            sync_q       <= {sync_q[0], tick_clk};
            sync_prev_q  <= sync_q[1];
            prime_q      <= {prime_q[1:0], 1'b1};
            running_q    <= running_d;
            alarm_q      <= alarm_d;
            div_enable_q <= div_enable_d;
            div_reset_q  <= div_reset_d;
        end
    end

    assign running    = running_q;
    assign alarm      = alarm_q;
    assign div_enable = div_enable_q;
    assign div_reset  = div_reset_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Bench for egg_timer_ctrl: directed scenarios plus random buttons/ticks
// against a seconds-arithmetic reference model.
module tb_egg_timer_ctrl;
    import egg_timer_pkg::*;

    localparam int ALARM = 10;
    localparam int MAXM  = 99;

    logic       clk_in = 1'b0;
    logic       reset_n;
    logic       tick_clk;
    logic       btn_start, btn_stop, btn_min, btn_sec, btn_clear;
    logic       div_enable, div_reset, running, alarm;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [2:0] state_o;

    egg_timer_ctrl #(.ALARM_SECS(ALARM), .MAX_MIN(MAXM)) dut (
        .clk_in     (clk_in),
        .reset_n    (reset_n),
        .tick_clk   (tick_clk),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_min    (btn_min),
        .btn_sec    (btn_sec),
        .btn_clear  (btn_clear),
        .div_enable (div_enable),
        .div_reset  (div_reset),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .alarm      (alarm),
        .state_o    (state_o)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // reference model: time held as plain minutes/seconds integers
    int         m_mm, m_ss, m_alarm;
    state_t     m_st;
    logic       m_divrst;
    logic [3:0] h;

    function automatic logic [22:0] dut_vec();
        return {div_enable, div_reset, min_tens, min_ones, sec_tens, sec_ones,
                running, alarm, state_o};
    endfunction

    function automatic logic [22:0] exp_vec(input int mm, input int ss, input state_t s,
                                            input logic dr);
        logic [3:0] a, b, c, d;
        a = 4'(mm / 10);
        b = 4'(mm % 10);
        c = 4'(ss / 10);
        d = 4'(ss % 10);
        return {(s == ST_RUN) || (s == ST_DONE), dr, a, b, c, d,
                s == ST_RUN, s == ST_DONE, 3'(s)};
    endfunction

    function automatic logic [22:0] mdl_vec();
        return exp_vec(m_mm, m_ss, m_st, m_divrst);
    endfunction

    task automatic model_reset();
        m_mm = 0; m_ss = 0; m_alarm = 0; m_st = ST_IDLE; m_divrst = 1'b1;
        h = {4{tick_clk}};
    endtask

    // one clock cycle: drive inputs, advance model, sample 1 time unit after the edge
    task automatic step(input logic stt, input logic sp, input logic mn, input logic sc,
                        input logic cl, input logic tk);
        state_t s0;
        logic   tk_eff;
        int     t;
        btn_start = stt; btn_stop = sp; btn_min = mn; btn_sec = sc; btn_clear = cl;
        tick_clk = tk;
        h = {h[2:0], tk};
        tk_eff = h[2] & ~h[3];
        s0 = m_st;
        m_divrst = 1'b0;
        if (cl) begin
            m_mm = 0; m_ss = 0; m_st = ST_IDLE; m_alarm = 0;
        end else if (sp) begin
            if (s0 == ST_RUN) m_st = ST_PAUSE;
            else if (s0 == ST_DONE) begin m_st = ST_IDLE; m_alarm = 0; end
        end else begin
            if (stt) begin
                if (s0 == ST_SET || s0 == ST_PAUSE) begin
                    m_st = ST_RUN;
                    m_divrst = (s0 == ST_SET);
                end
            end else if ((mn || sc) && (s0 == ST_IDLE || s0 == ST_SET)) begin
                if (mn) m_mm = (m_mm == MAXM) ? 0 : m_mm + 1;
                if (sc) m_ss = (m_ss + 1) % 60;
                m_st = (m_mm != 0 || m_ss != 0) ? ST_SET : ST_IDLE;
            end
            if (tk_eff && s0 == ST_RUN) begin
                t = m_mm * 60 + m_ss - 1;
                m_mm = t / 60;
                m_ss = t % 60;
                if (t == 0) begin m_st = ST_DONE; m_alarm = ALARM; end
            end else if (tk_eff && s0 == ST_DONE) begin
                m_alarm = m_alarm - 1;
                if (m_alarm == 0) m_st = ST_IDLE;
            end
        end
        @(posedge clk_in);
        #1;
        btn_start = 0; btn_stop = 0; btn_min = 0; btn_sec = 0; btn_clear = 0;
    endtask

    task automatic tick1();
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        logic [22:0] want;
        reset_n = 0; tick_clk = 0;
        btn_start = 0; btn_stop = 0; btn_min = 0; btn_sec = 0; btn_clear = 0;
        repeat (3) @(posedge clk_in);
        #1;
        want = exp_vec(0, 0, ST_IDLE, 1'b1);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL reset_hold: got %h want %h", dut_vec(), want);
        end
        reset_n = 1;
        model_reset();
        step(0, 0, 0, 0, 0, 0);
        want = exp_vec(0, 0, ST_IDLE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), want);
        end
    endtask

    task automatic test_countdown();
        logic [22:0] want;
        step(0, 0, 0, 0, 1, 0);
        repeat (3) step(0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        want = exp_vec(1, 3, ST_SET, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL countdown_set: got %h want %h", dut_vec(), want);
        end
        step(1, 0, 0, 0, 0, 0);
        want = exp_vec(1, 3, ST_RUN, 1'b1);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL countdown_start_divreset: got %h want %h", dut_vec(), want);
        end
        for (int i = 0; i < 63; i++) begin
            tick1();
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL countdown_tick%0d: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
        want = exp_vec(0, 0, ST_DONE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL countdown_done: got %h want %h", dut_vec(), want);
        end
        repeat (9) tick1();
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL alarm_9_ticks: got %h want %h", dut_vec(), want);
        end
        tick1();
        want = exp_vec(0, 0, ST_IDLE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL alarm_expired: got %h want %h", dut_vec(), want);
        end
    endtask

    task automatic test_pause_resume();
        logic [22:0] want;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        tick1();
        want = exp_vec(0, 59, ST_RUN, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL run_first_tick: got %h want %h", dut_vec(), want);
        end
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0);
        want = exp_vec(0, 59, ST_PAUSE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL stop_beats_tick: got %h want %h", dut_vec(), want);
        end
        repeat (2) tick1();
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL pause_holds: got %h want %h", dut_vec(), want);
        end
        step(1, 0, 0, 0, 0, 0);
        want = exp_vec(0, 59, ST_RUN, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL resume_no_divreset: got %h want %h", dut_vec(), want);
        end
    endtask

    task automatic test_wrap();
        logic [22:0] want;
        step(0, 0, 0, 0, 1, 0);
        repeat (59) step(0, 0, 0, 1, 0, 0);
        want = exp_vec(0, 59, ST_SET, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL sec_59: got %h want %h", dut_vec(), want);
        end
        step(0, 0, 0, 1, 0, 0);
        want = exp_vec(0, 0, ST_IDLE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL sec_wrap: got %h want %h", dut_vec(), want);
        end
        repeat (99) step(0, 0, 1, 0, 0, 0);
        want = exp_vec(99, 0, ST_SET, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL min_max: got %h want %h", dut_vec(), want);
        end
        step(0, 0, 1, 0, 0, 0);
        want = exp_vec(0, 0, ST_IDLE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL min_wrap: got %h want %h", dut_vec(), want);
        end
    endtask

    task automatic test_start_idle_clear();
        logic [22:0] want;
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        want = exp_vec(0, 0, ST_IDLE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL start_in_idle: got %h want %h", dut_vec(), want);
        end
        repeat (2) step(0, 0, 1, 0, 0, 0);
        repeat (30) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        want = exp_vec(2, 30, ST_RUN, 1'b1);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL run_0230: got %h want %h", dut_vec(), want);
        end
        step(0, 0, 0, 0, 1, 0);
        want = exp_vec(0, 0, ST_IDLE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL clear_in_run: got %h want %h", dut_vec(), want);
        end
    endtask

    task automatic test_reset_mid_done();
        logic [22:0] want;
        step(0, 0, 0, 0, 1, 0);
        repeat (2) step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        repeat (2) tick1();
        want = exp_vec(0, 0, ST_DONE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL pre_reset_done: got %h want %h", dut_vec(), want);
        end
        step(0, 0, 0, 0, 0, 1);
        #2 reset_n = 0;
        #2;
        want = exp_vec(0, 0, ST_IDLE, 1'b1);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL async_reset_done: got %h want %h", dut_vec(), want);
        end
        @(posedge clk_in);
        #1;
        reset_n = 1;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 1);
            vectors++;
            if (dut.tick_pulse !== 1'b0 || dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL no_spurious_tick%0d: tick=%b got %h want %h",
                         i, dut.tick_pulse, dut_vec(), mdl_vec());
            end
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_done_stop();
        logic [22:0] want;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        tick1();
        want = exp_vec(0, 0, ST_DONE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL done_entered: got %h want %h", dut_vec(), want);
        end
        step(0, 1, 0, 0, 0, 0);
        want = exp_vec(0, 0, ST_IDLE, 1'b0);
        vectors++;
        if (dut_vec() !== want) begin
            miscompares++;
            $display("FAIL done_stop_ack: got %h want %h", dut_vec(), want);
        end
    endtask

    task automatic test_random();
        logic cl, sp, stt, mn, sc, tk;
        step(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 1500; i++) begin
            cl  = ($urandom_range(0, 99) < 1);
            sp  = ($urandom_range(0, 99) < 4);
            stt = ($urandom_range(0, 99) < 8);
            mn  = ($urandom_range(0, 99) < 2);
            sc  = ($urandom_range(0, 99) < 20);
            tk  = ($urandom_range(0, 2) == 0) ? ~tick_clk : tick_clk;
            step(stt, sp, mn, sc, cl, tk);
            vectors++;
            if (dut_vec() !== mdl_vec()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h want %h", i, dut_vec(), mdl_vec());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_countdown();
        test_pause_resume();
        test_wrap();
        test_start_idle_clear();
        test_reset_mid_done();
        test_done_stop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
